axis_frame_reader: RTL
======================

# axis_frame_reader

Frame source for the convolution datapath. On `start`, reads one IMG_WIDTH×IMG_HEIGHT frame in row-major order from a synchronous single-port pixel memory. It emits the frame as an AXI4-Stream master, with start-of-frame on `tuser` and end-of-line on `tlast`. Its output drives the conv layer's S00 slave port directly, closing the memory-to-convolution path. Throughput is one pixel per clock when `tready` is held high.

## Interface
- `DATA_WIDTH`, 32: pixel / `tdata` width, a multiple of 8.
- `ADDR_WIDTH`, 14: pixel memory address width.
- `IMG_WIDTH`, 128: pixels per line, ≥2.
- `IMG_HEIGHT`, 128: lines per frame, ≥1. IMG_WIDTH×IMG_HEIGHT ≤ 2^ADDR_WIDTH.
- `clk` in 1: single clock for all logic.
- `resetn` in 1: reset, asynchronous assert, active-low.
- `start` in 1: frame request; accepted only while `busy`=0.
- `frame_base` in ADDR_WIDTH: first pixel address; latched when `start` is accepted.
- `busy` out 1: a frame is in progress.
- `done` out 1: one-cycle pulse after the last beat of the frame handshakes.
- `mem_rd_en` out 1: memory read strobe.
- `mem_rd_addr` out ADDR_WIDTH: memory read address.
- `mem_rd_data` in DATA_WIDTH: read data, valid exactly 1 cycle after `mem_rd_en`.
- `m_axis_tvalid` out 1: AXIS valid.
- `m_axis_tdata` out DATA_WIDTH: pixel.
- `m_axis_tstrb` out DATA_WIDTH/8: all ones whenever `tvalid`=1.
- `m_axis_tlast` out 1: last pixel of a line.
- `m_axis_tuser` out 1: first pixel of the frame.
- `m_axis_tready` in 1: downstream ready.

## Operation
- FSM states:
  - IDLE: `start`=1 latches `frame_base`, clears `col`/`row`, and moves to RUN.
  - RUN: issues reads. After the read for (row=IMG_HEIGHT-1, col=IMG_WIDTH-1), moves to DRAIN.
  - DRAIN: waits until the buffer is empty and no read is in flight, then pulses `done` and returns to IDLE.
- Addressing: `mem_rd_addr` = `frame_base` + row·IMG_WIDTH + col, modulo 2^ADDR_WIDTH (wraps, no error).
  - Implemented as a running address register incremented by 1 per issued read, not a multiplier.
- Each issued read carries two sideband flags through a one-stage in-flight register, aligned with `mem_rd_data`:
  - `sof` = (row=0 && col=0).
  - `eol` = (col=IMG_WIDTH-1).
- Returned data and flags are written into a 2-entry output buffer, whose head drives `m_axis_*`.
- Credit rule: `mem_rd_en` = (state=RUN) && (count + inflight − pop < 2).
  - pop = `tvalid` && `tready`.
  - The buffer never overflows, and no read data is ever dropped.
- AXIS rules:
  - Once `tvalid`=1, `tdata`/`tlast`/`tuser` are held stable until `tready`=1.
  - `tvalid` never depends combinationally on `tready`.
- `start` asserted while `busy`=1 is ignored; it is not queued.
- `busy` = (state≠IDLE).

## Timing
- Reset values:
  - `busy`, `done`, `mem_rd_en`, `m_axis_tvalid`, `tlast`, `tuser` = 0.
  - `mem_rd_addr`, `tdata`, `tstrb` = 0.
  - FSM = IDLE; buffer count = 0; no read in flight.
- Latency: with `start` sampled at edge E0, the first `mem_rd_en` is high in the cycle after E0, and `m_axis_tvalid` rises after E2.
- Throughput: with `tready` held at 1, exactly one beat per clock from the first beat through the last. A frame takes IMG_WIDTH·IMG_HEIGHT + 3 cycles from `start` to `done`.
- Backpressure:
  - `tready`=0 stops reads within 1 cycle; at most 2 pixels are buffered.
  - On `tready` rising, beats resume on the same edge, with no bubble beyond buffer refill.
- Simultaneous pop and push on a full buffer: allowed, and count stays 2.
- `done` is high for the single cycle after the final beat's handshake. `start` may be accepted in that same cycle (`busy` is already 0).
- Reset mid-frame: all state clears asynchronously, and `tvalid` drops immediately. The partial frame is abandoned; the next frame begins with `tuser`=1.

## Structure
- Shared package `conv_axis_pkg`: DATA_WIDTH/ADDR_WIDTH defaults, the FSM state encoding, and a `tuser` bit-index constant (SOF=0).
- Sub-module `axis_skid_buf2`: 2-entry FIFO carrying {data, last, user} with push/pop/count. It is reusable on other AXIS masters in the conv layer.

## Test plan
- 4×3 frame, `frame_base`=0x10, `tready`=1: 12 beats of data 0x10..0x1B on consecutive cycles. `tuser` is 1 only on beat 0; `tlast` is 1 on beats 3, 7, 11; `done` pulses once.
- Same frame, `tready` toggling 1-0-1-0: every pixel appears exactly once and in order, held stable while `tready`=0. No more than 2 reads are outstanding beyond the head beat.
- `frame_base`=0x3FFE, ADDR_WIDTH=14, 4×1 frame: addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- `start` pulsed mid-frame: ignored. A second `start` in the `done` cycle launches the next frame, whose first beat has `tuser`=1.
- `resetn` asserted after beat 5 of a 4×3 frame: `tvalid`=0 immediately. After release plus `start`, the frame restarts at `frame_base`.
- Random `tready` over a 128×128 frame against a scoreboard: 16384 beats, 128 `tlast`, 1 `tuser`, zero data mismatches.

Source files
------------

// File: rtl/conv_axis_pkg.sv
// Shared definitions for the AXI4-Stream sources feeding the convolution layer.
package conv_axis_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int ADDR_WIDTH_DEF = 14;

   // tuser bit carrying start-of-frame
   localparam int TUSER_SOF   = 0;
   localparam int TUSER_WIDTH = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } rd_state_e;

   // Buffer slots that will be occupied after this cycle's pop: stored
   // beats plus the read whose data is still on its way from memory.
   function automatic logic [1:0] credit_used(input logic [1:0] count,
                                              input logic       inflight,
                                              input logic       pop);
      return count + {1'b0, inflight} - {1'b0, pop};
   endfunction

endpackage

// File: rtl/axis_skid_buf2.sv
// Two-entry FIFO holding {data, last, user} for an AXIS master. The head
// entry drives the stream outputs and changes only when popped or empty,
// so payload stays stable while the consumer stalls.
import conv_axis_pkg::*;

module axis_skid_buf2 #(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int USER_WIDTH = TUSER_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  last_i,
   input  logic [USER_WIDTH-1:0] user_i,
   input  logic                  pop_i,
   output logic [1:0]            count_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  last_o,
   output logic [USER_WIDTH-1:0] user_o
);

   localparam int EW = DATA_WIDTH + 1 + USER_WIDTH;

   logic [EW-1:0] head_q, head_d;
   logic [EW-1:0] tail_q, tail_d;
   logic [1:0]    count_q, count_d;
   logic [EW-1:0] in_s;
   logic          pop_s;

   assign in_s  = {data_i, last_i, user_i};
   assign pop_s = pop_i && (count_q != 2'd0);

   // Next-state of the two slots and the occupancy count
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case ({push_i, pop_s})
         2'b10: begin
            if (count_q == 2'd0) begin
               head_d  = in_s;
               count_d = 2'd1;
            end else if (count_q == 2'd1) begin
               tail_d  = in_s;
               count_d = 2'd2;
            end else begin
               count_d = count_q;
            end
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd1) begin
               head_d = in_s;
            end else begin
               head_d = tail_q;
               tail_d = in_s;
            end
         end
         default: begin
            count_d = count_q;
         end
      endcase
   end

   // Slot and count registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign data_o  = head_q[EW-1 -: DATA_WIDTH];
   assign last_o  = head_q[USER_WIDTH];
   assign user_o  = head_q[USER_WIDTH-1:0];

endmodule

// File: rtl/axis_frame_reader.sv
// Reads one frame row-major from a synchronous pixel memory and streams it
// as AXI4-Stream (tuser = start of frame, tlast = end of line). Reads are
// credit-limited so the 2-entry output buffer can never overflow.
import conv_axis_pkg::*;

module axis_frame_reader #(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int IMG_WIDTH  = 128,
   parameter int IMG_HEIGHT = 128
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   frame_base,
   output logic                    busy,
   output logic                    done,
   output logic                    mem_rd_en,
   output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
   input  logic [DATA_WIDTH-1:0]   mem_rd_data,
   output logic                    m_axis_tvalid,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
   output logic                    m_axis_tlast,
   output logic                    m_axis_tuser,
   input  logic                    m_axis_tready
);

   localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [CW-1:0]         COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0]         ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   rd_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;
   logic                  infl_vld_q, infl_vld_d;
   logic                  infl_sof_q, infl_sof_d;
   logic                  infl_eol_q, infl_eol_d;
   logic                  done_q, done_d;

   logic [1:0]             buf_count_s;
   logic                   pop_s;
   logic                   rd_en_s;
   logic [TUSER_WIDTH-1:0] user_in_s;
   logic [TUSER_WIDTH-1:0] user_out_s;

   assign pop_s   = m_axis_tvalid && m_axis_tready;
   assign rd_en_s = (state_q == ST_RUN) &&
                    (credit_used(buf_count_s, infl_vld_q, pop_s) < 2'd2);

   // FSM next state, pixel walk and in-flight sideband flags
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      col_d      = col_q;
      row_d      = row_q;
      done_d     = 1'b0;
      infl_vld_d = rd_en_s;
      infl_sof_d = (row_q == '0) && (col_q == '0);
      infl_eol_d = (col_q == COL_LAST);
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               addr_d  = frame_base;
               col_d   = '0;
               row_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (rd_en_s) begin
               addr_d = addr_q + ADDR_ONE;
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  if (row_q == ROW_LAST) begin
                     row_d   = '0;
                     state_d = ST_DRAIN;
                  end else begin
                     row_d = row_q + RW'(1);
                  end
               end else begin
                  col_d = col_q + CW'(1);
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            // Finish on the edge that pops the final beat so done lands in
            // the very next cycle.
            if (!infl_vld_q &&
                ((buf_count_s == 2'd0) || ((buf_count_s == 2'd1) && pop_s))) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Address walk, in-flight read tracking and done pulse
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         addr_q     <= '0;
         col_q      <= '0;
         row_q      <= '0;
         infl_vld_q <= 1'b0;
         infl_sof_q <= 1'b0;
         infl_eol_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         addr_q     <= addr_d;
         col_q      <= col_d;
         row_q      <= row_d;
         infl_vld_q <= infl_vld_d;
         infl_sof_q <= infl_sof_d;
         infl_eol_q <= infl_eol_d;
         done_q     <= done_d;
      end
   end

   // Place the start-of-frame flag at its tuser bit position
   always_comb begin
      user_in_s            = '0;
      user_in_s[TUSER_SOF] = infl_sof_q;
   end

   axis_skid_buf2 #(
      .DATA_WIDTH (DATA_WIDTH),
      .USER_WIDTH (TUSER_WIDTH)
   ) u_buf (
      .clk_i   (clk),
      .rst_ni  (resetn),
      .push_i  (infl_vld_q),
      .data_i  (mem_rd_data),
      .last_i  (infl_eol_q),
      .user_i  (user_in_s),
      .pop_i   (pop_s),
      .count_o (buf_count_s),
      .data_o  (m_axis_tdata),
      .last_o  (m_axis_tlast),
      .user_o  (user_out_s)
   );

   assign busy          = (state_q != ST_IDLE);
   assign done          = done_q;
   assign mem_rd_en     = rd_en_s;
   assign mem_rd_addr   = addr_q;
   assign m_axis_tvalid = (buf_count_s != 2'd0);
   assign m_axis_tuser  = user_out_s[TUSER_SOF];
   assign m_axis_tstrb  = m_axis_tvalid ? {(DATA_WIDTH/8){1'b1}} : {(DATA_WIDTH/8){1'b0}};

endmodule
